// File: rtl/logic_unit_pkg.sv
// Shared types for the bitwise logic unit: op encoding, buffer depth, per-entry flags.
package logic_unit_pkg;

  localparam int LU_DEPTH = 2;

  typedef enum logic [2:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_XOR    = 3'd2,
    OP_NAND   = 3'd3,
    OP_NOR    = 3'd4,
    OP_XNOR   = 3'd5,
    OP_PASS_A = 3'd6,
    OP_NOT_A  = 3'd7
  } op_e;

  typedef struct packed {
    logic zero;
    logic sign;
  } lu_flags_t;

endpackage

// File: rtl/logic_op_core.sv
// Combinational WIDTH-bit logic function: y = f(op, a, b).
module logic_op_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = '0;
    case (op_e'(op_i))
      OP_AND:    y_o = a_i & b_i;
      OP_OR:     y_o = a_i | b_i;
      OP_XOR:    y_o = a_i ^ b_i;
      OP_NAND:   y_o = ~(a_i & b_i);
      OP_NOR:    y_o = ~(a_i | b_i);
      OP_XNOR:   y_o = ~(a_i ^ b_i);
      OP_PASS_A: y_o = a_i;
      OP_NOT_A:  y_o = ~a_i;
      default:   y_o = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit.sv
// Bitwise logic unit with a 2-entry FIFO result buffer and valid/ready on both sides.
// Optional zero/sign flag storage is enabled by defining LOGIC_UNIT_FLAGS_EN.
module logic_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             sign
);

  if (DEPTH != LU_DEPTH) begin : g_depth_chk
    $error("logic_unit: DEPTH must be 2");
  end

  logic [WIDTH-1:0] res;

  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .op_i (op),
    .a_i  (a),
    .b_i  (b),
    .y_o  (res)
  );

  logic [LU_DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic       wr_q, wr_d, rd_q, rd_d;
  logic [1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic push, pop;

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign y         = y_q;

  // Head is re-registered so outputs hold their last value once the buffer drains.
  always_comb begin
    data_d = data_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    if (push) begin
      data_d[wr_q] = res;
      wr_d         = ~wr_q;
    end
    if (pop) rd_d = ~rd_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    y_d = (cnt_d != 2'd0) ? data_d[rd_d] : y_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      cnt_q  <= 2'd0;
      y_q    <= '0;
    end else begin
      data_q <= data_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      y_q    <= y_d;
    end
  end

`ifdef LOGIC_UNIT_FLAGS_EN
  lu_flags_t [LU_DEPTH-1:0] flg_q, flg_d;
  lu_flags_t res_flg, hd_q, hd_d;

  always_comb begin
    res_flg.zero = (res == '0);
    res_flg.sign = res[WIDTH-1];
    flg_d = flg_q;
    if (push) flg_d[wr_q] = res_flg;
    hd_d = (cnt_d != 2'd0) ? flg_d[rd_d] : hd_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flg_q <= '0;
      hd_q  <= '0;
    end else begin
      flg_q <= flg_d;
      hd_q  <= hd_d;
    end
  end

  assign zero = hd_q.zero;
  assign sign = hd_q.sign;
`else
  assign zero = 1'b0;
  assign sign = 1'b0;
`endif

  a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= 2'd2);

endmodule

// File: tb/tb_logic_unit.sv
// Directed, table-driven bench for logic_unit: reset, op sweep, stall, steady flow, mid-run reset.
module tb_logic_unit;

`ifdef LOGIC_UNIT_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [2:0] op;
  logic [7:0] a, b, y;
  logic       out_valid, out_ready, zero, sign;

  int n_chk  = 0;
  int n_fail = 0;

  logic_unit #(.WIDTH(8), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .zero      (zero),
    .sign      (sign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    logic       z;
    logic       s;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string name, input logic [7:0] ey, input logic ez, input logic es);
    chk({name, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, ".y"}, {24'd0, y}, {24'd0, ey});
    chk({name, ".zero"}, {31'd0, zero}, {31'd0, ez & FLAGS});
    chk({name, ".sign"}, {31'd0, sign}, {31'd0, es & FLAGS});
  endtask

  initial begin
    vecs[0]  = '{3'd0, 8'hA5, 8'h0F, 8'h05, 1'b0, 1'b0};
    vecs[1]  = '{3'd1, 8'hA5, 8'h0F, 8'hAF, 1'b0, 1'b1};
    vecs[2]  = '{3'd2, 8'hA5, 8'h0F, 8'hAA, 1'b0, 1'b1};
    vecs[3]  = '{3'd3, 8'hA5, 8'h0F, 8'hFA, 1'b0, 1'b1};
    vecs[4]  = '{3'd4, 8'hA5, 8'h0F, 8'h50, 1'b0, 1'b0};
    vecs[5]  = '{3'd5, 8'hA5, 8'h0F, 8'h55, 1'b0, 1'b0};
    vecs[6]  = '{3'd6, 8'hA5, 8'h0F, 8'hA5, 1'b0, 1'b1};
    vecs[7]  = '{3'd7, 8'hA5, 8'h0F, 8'h5A, 1'b0, 1'b0};
    vecs[8]  = '{3'd0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[9]  = '{3'd4, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0};
    vecs[10] = '{3'd5, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0};
    vecs[11] = '{3'd7, 8'h7F, 8'h00, 8'h80, 1'b0, 1'b1};
    vecs[12] = '{3'd3, 8'h3C, 8'hC3, 8'hFF, 1'b0, 1'b1};

    // Reset held with a beat presented.
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    op = 3'd1; a = 8'hF0; b = 8'h3C;
    tick(); tick();
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.y", {24'd0, y}, 32'd0);
    chk("rst.zero", {31'd0, zero}, 32'd0);
    chk("rst.sign", {31'd0, sign}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk_head("first_or", 8'hFC, 1'b0, 1'b1);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("drain.out_valid", {31'd0, out_valid}, 32'd0);
    chk("drain.y_hold", {24'd0, y}, 32'h0000_00FC);

    // Op sweep and boundary patterns, one result per cycle.
    in_valid = 1'b1;
    for (int i = 0; i < 13; i++) begin
      op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
      tick();
      chk_head($sformatf("vec%0d", i), vecs[i].y, vecs[i].z, vecs[i].s);
      chk($sformatf("vec%0d.in_ready", i), {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("sweep_end.out_valid", {31'd0, out_valid}, 32'd0);

    // Stall: two beats fill the buffer, the third waits.
    out_ready = 1'b0; in_valid = 1'b1;
    op = 3'd0; a = 8'hFF; b = 8'h00;
    tick();
    chk("stall1.in_ready", {31'd0, in_ready}, 32'd1);
    op = 3'd2; a = 8'h12; b = 8'h12;
    tick();
    chk("stall2.in_ready", {31'd0, in_ready}, 32'd0);
    op = 3'd1; a = 8'h01; b = 8'h02;
    tick();
    chk("stall3.in_ready", {31'd0, in_ready}, 32'd0);
    chk_head("stall3.head", 8'h00, 1'b1, 1'b0);
    out_ready = 1'b1;
    tick();
    chk("pop1.in_ready", {31'd0, in_ready}, 32'd1);
    chk_head("pop1.head", 8'h00, 1'b1, 1'b0);
    tick();
    chk_head("pop2.head", 8'h03, 1'b0, 1'b0);
    in_valid = 1'b0;
    tick();
    chk("pop3.out_valid", {31'd0, out_valid}, 32'd0);
    chk("pop3.y_hold", {24'd0, y}, 32'h0000_0003);

    // Steady state at one entry: push and pop together for 10 cycles.
    out_ready = 1'b0; in_valid = 1'b1; op = 3'd6; b = 8'h00; a = 8'h10;
    tick();
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      a = 8'h11 + 8'(k);
      tick();
      chk($sformatf("flow%0d.y", k), {24'd0, y}, {24'd0, 8'h11 + 8'(k)});
      chk($sformatf("flow%0d.in_ready", k), {31'd0, in_ready}, 32'd1);
      chk($sformatf("flow%0d.out_valid", k), {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("flow_end.out_valid", {31'd0, out_valid}, 32'd0);

    // Mid-run reset with two entries pending.
    out_ready = 1'b0; in_valid = 1'b1; op = 3'd6; a = 8'h81;
    tick();
    a = 8'h82;
    tick();
    chk("pre_rst.in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst.in_ready", {31'd0, in_ready}, 32'd1);
    chk("async_rst.y", {24'd0, y}, 32'd0);
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("post_rst%0d.out_valid", k), {31'd0, out_valid}, 32'd0);
    end
    in_valid = 1'b1; op = 3'd0; a = 8'h00; b = 8'h00;
    tick();
    chk_head("post_rst.and00", 8'h00, 1'b1, 1'b0);
    in_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
